scan_decoder: RTL

Parametrised, registered N-to-2^N one-hot decoder, successor to the single-bit 1-to-2 decoder. It has two modes. In direct mode it decodes a handshaked select value. In scan mode it steps one active output through every position, holding each for a programmable dwell time. It drives display-digit and row-strobe lines in the team's board-level designs.

---
 rtl/scan_decoder_pkg.sv | 13 +
 rtl/scan_decoder_dwell_timer.sv | 32 +++
 rtl/scan_decoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan_decoder block.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DIRECT = 2'b01,
        SCAN   = 2'b10
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_dwell_timer.sv
// Free-running dwell counter: ticks when the count reaches DWELL-1, then wraps to 0.
module dwell_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = ($clog2(DWELL + 1) > 1) ? $clog2(DWELL + 1) : 1;

    logic [CntW-1:0] count_q, count_d;

    assign tick = (count_q == CntW'(DWELL - 1));

    always_comb begin
        count_d = count_q + CntW'(1);
        if (clr || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with direct (handshaked) and scan modes.
// Define SCAN_DECODER_ACTIVE_LOW_EN to drive out active-low (idle value all-ones).
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        mode,
    input  logic                        sel_valid,
    input  logic [SEL_W-1:0]            sel,
    output logic                        sel_ready,
    output logic [(2**SEL_W)-1:0]       out,
    output logic                        out_valid,
    output logic [SEL_W-1:0]            idx,
    output logic                        wrap
);

    localparam int unsigned NUM_OUT = 2 ** SEL_W;

    state_e             state_q, state_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               wrap_q, wrap_d;
    logic               tick;
    logic               timer_clr;

    // Held in clear outside SCAN and on the entry edge so the first position gets a full dwell.
    assign timer_clr = (state_q != SCAN) || (state_d != SCAN);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (!en) begin
            state_d = IDLE;
        end else if (mode == MODE_DIRECT) begin
            state_d = DIRECT;
        end else begin
            state_d = SCAN;
        end
    end

    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        unique case (state_d)
            IDLE: begin
                idx_d   = '0;
                valid_d = 1'b0;
            end
            DIRECT: begin
                if (state_q == DIRECT && sel_valid) begin
                    idx_d   = sel;
                    valid_d = 1'b1;
                end
            end
            SCAN: begin
                valid_d = 1'b1;
                if (state_q != SCAN) begin
                    idx_d = '0;
                end else if (tick) begin
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == SEL_W'(NUM_OUT - 1));
                end
            end
            default: begin
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
        // Out only changes when idx is (re)loaded; otherwise it holds, including the
        // pre-accept zero after entering DIRECT from IDLE.
        out_d = out_q;
        if (state_d == IDLE) begin
            out_d = '0;
        end else if (idx_d != idx_q || valid_d != valid_q || state_d != state_q) begin
            out_d = valid_d ? (NUM_OUT'(1) << idx_d) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            out_q   <= out_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign sel_ready = (state_q == DIRECT);
    assign out_valid = valid_q;
    assign idx       = idx_q;
    assign wrap      = wrap_q;
`ifdef SCAN_DECODER_ACTIVE_LOW_EN
    assign out = ~out_q;
`else
    assign out = out_q;
`endif

endmodule
